tsn_csr_arbiter: RTL and testbench

Two-host CSR arbiter for the TSN subsystem register space. It shares one downstream Avalon-MM CSR agent port between two Avalon-MM hosts, the management CPU bridge and the boot-time configuration sequencer, using round-robin arbitration with a single outstanding transaction. Accesses outside the implemented register window are completed internally as reserved locations: writes are discarded and reads return zero.

---
 rtl/tsn_csr_arbiter_if.sv | 32 +++
 rtl/tsn_csr_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_tsn_csr_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tsn_csr_arbiter_if.sv
// ---------------------------------------------------------------------------
// tsn_csr_arbiter_if
// Avalon-MM CSR bus bundle shared by both host ports and the agent port of
// tsn_csr_arbiter.
//   master modport : drives address/write/read/writedata, receives
//                    waitrequest/readdata/readdatavalid (a host, or the
//                    arbiter facing the agent).
//   slave modport  : the opposite direction (the arbiter facing a host, or
//                    the agent itself).
// ---------------------------------------------------------------------------
interface tsn_csr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  write;
  logic                  read;
  logic [DATA_WIDTH-1:0] writedata;
  logic                  waitrequest;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;

  modport master (
    output address, write, read, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, write, read, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/tsn_csr_arbiter.sv
// ---------------------------------------------------------------------------
// tsn_csr_arbiter
// Shares one Avalon-MM CSR agent between two hosts (management CPU bridge on
// h0, boot configuration sequencer on h1) with round-robin arbitration and a
// single outstanding transaction. Addresses at or above MAP_WORDS complete
// internally: writes are dropped, reads return zero.
//
// Ports:
//   clk, rst_n   single clock, asynchronous active-low reset
//   h0, h1       host buses (slave modport of tsn_csr_arbiter_if)
//   agent        downstream agent bus (master modport)
//   err_o        sticky agent-timeout flag
//   err_clr_i    clears err_o (a timeout in the same cycle wins)
//
// Optional feature: define TSN_CSR_TIMEOUT_EN to add an agent watchdog of
// TIMEOUT_CYCLES cycles; without it the arbiter waits on the agent forever
// and err_o is tied low.
// ---------------------------------------------------------------------------
module tsn_csr_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int MAP_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  tsn_csr_arbiter_if.slave  h0,
  tsn_csr_arbiter_if.slave  h1,
  tsn_csr_arbiter_if.master agent,
  output logic              err_o,
  input  logic              err_clr_i
);

  typedef enum logic [2:0] {IDLE, ISSUE, RDWAIT, DONE, RESP} state_t;

  state_t                state;
  state_t                state_nxt;

  logic                  last_gnt;
  logic                  gnt;
  logic                  is_wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  logic                  req0;
  logic                  req1;
  logic                  sel;
  logic                  sel_wr;
  logic                  sel_in_win;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  take;
  logic                  cap;
  logic                  tmo;
  logic                  tmo_hit;

  assign req0 = h0.read | h0.write;
  assign req1 = h1.read | h1.write;

  // On a tie the host that was not granted last wins; otherwise the lone
  // requester is chosen.
  assign sel        = (req0 & req1) ? ~last_gnt : req1;
  assign sel_addr   = sel ? h1.address   : h0.address;
  assign sel_wdata  = sel ? h1.writedata : h0.writedata;
  assign sel_wr     = sel ? h1.write     : h0.write;   // write wins over read
  assign sel_in_win = (32'(sel_addr) < 32'(MAP_WORDS));

`ifdef TSN_CSR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (take) begin
      tmo_cnt <= '0;
    end else if (state == ISSUE || state == RDWAIT) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // Fires on the TIMEOUT_CYCLES-th cycle spent in ISSUE/RDWAIT.
  assign tmo = (state == ISSUE || state == RDWAIT) &&
               (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (tmo_hit) begin
      err_o <= 1'b1;
    end else if (err_clr_i) begin
      err_o <= 1'b0;
    end
  end
`else
  logic unused_clr;

  assign tmo        = 1'b0;
  assign err_o      = 1'b0;
  assign unused_clr = err_clr_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Last-grant pointer starts at host 1 so host 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
      gnt      <= 1'b0;
      is_wr    <= 1'b0;
    end else if (take) begin
      last_gnt <= sel;
      gnt      <= sel;
      is_wr    <= sel_wr;
    end
  end

  // Transaction payload; only ever observed through state-qualified outputs.
  always_ff @(posedge clk) begin
    if (take) begin
      addr  <= sel_addr;
      wdata <= sel_wdata;
      rdata <= '0;
    end else if (cap) begin
      rdata <= agent.readdata;
    end else if (tmo_hit) begin
      rdata <= '1;
    end
  end

  always_comb begin
    state_nxt           = state;
    take                = 1'b0;
    cap                 = 1'b0;
    tmo_hit             = 1'b0;
    h0.waitrequest      = 1'b1;
    h1.waitrequest      = 1'b1;
    h0.readdatavalid    = 1'b0;
    h1.readdatavalid    = 1'b0;
    h0.readdata         = '0;
    h1.readdata         = '0;
    agent.read          = 1'b0;
    agent.write         = 1'b0;
    agent.address       = '0;
    agent.writedata     = '0;

    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          take      = 1'b1;
          state_nxt = sel_in_win ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        agent.read      = ~is_wr;
        agent.write     = is_wr;
        agent.address   = addr;
        agent.writedata = wdata;
        if (!agent.waitrequest) begin
          state_nxt = is_wr ? DONE : RDWAIT;
        end else if (tmo) begin
          tmo_hit   = 1'b1;
          state_nxt = DONE;
        end
      end
      RDWAIT: begin
        if (agent.readdatavalid) begin
          cap       = 1'b1;
          state_nxt = DONE;
        end else if (tmo) begin
          tmo_hit   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        h0.waitrequest = gnt;
        h1.waitrequest = ~gnt;
        state_nxt      = is_wr ? IDLE : RESP;
      end
      RESP: begin
        h0.readdatavalid = ~gnt;
        h1.readdatavalid = gnt;
        h0.readdata      = gnt ? '0 : rdata;
        h1.readdata      = gnt ? rdata : '0;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tsn_csr_arbiter.sv
`timescale 1ns/1ps
module tb_tsn_csr_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int MAP  = 1024;
  localparam int TMO  = 256;
  localparam int RING = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic err;

  always #5 clk = ~clk;

  tsn_csr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) h0_bus ();
  tsn_csr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) h1_bus ();
  tsn_csr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_bus ();

  tsn_csr_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAP_WORDS(MAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .h0(h0_bus), .h1(h1_bus), .agent(a_bus),
    .err_o(err), .err_clr_i(err_clr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- agent responder configuration and statistics ----------
  int            cfg_stall = 0;
  int            cfg_delay = 1;   // cycles from acceptance to readdatavalid; <0 never
  logic [DW-1:0] cfg_rdata = '0;
  int            a_rd_cycles = 0;
  int            a_wr_cycles = 0;
  logic [AW-1:0] last_a_addr = '0;
  logic [DW-1:0] last_a_wd = '0;
  time           t_arv = 0;
  time           t_hrdv = 0;

  initial begin
    int cmd_cnt;
    int resp_cnt;
    cmd_cnt = 0;
    resp_cnt = 0;
    a_bus.waitrequest   = 1'b1;
    a_bus.readdatavalid = 1'b0;
    a_bus.readdata      = 32'hDEADBEEF;
    forever begin
      @(posedge clk); #1;
      a_bus.readdatavalid = 1'b0;
      a_bus.readdata      = 32'hDEADBEEF;
      if (!rst_n) begin
        cmd_cnt = 0;
        resp_cnt = 0;
        a_bus.waitrequest = 1'b1;
      end else begin
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            a_bus.readdatavalid = 1'b1;
            a_bus.readdata      = cfg_rdata;
            t_arv               = $time;
          end
        end
        if (a_bus.read || a_bus.write) begin
          if (a_bus.write) a_wr_cycles++;
          if (a_bus.read)  a_rd_cycles++;
          last_a_addr = a_bus.address;
          last_a_wd   = a_bus.writedata;
          a_bus.waitrequest = (cmd_cnt < cfg_stall);
          if (cmd_cnt == cfg_stall && a_bus.read && cfg_delay > 0) resp_cnt = cfg_delay;
          cmd_cnt++;
        end else begin
          a_bus.waitrequest = 1'b1;
          cmd_cnt = 0;
        end
      end
    end
  end

  // ---------------- transaction-level model + per-cycle compare -----------
  bit            exp_wrq [2][RING];
  bit            exp_rdv [2][RING];
  logic [DW-1:0] exp_rd  [2][RING];
  bit            exp_rdc [RING];
  bit            exp_wrc [RING];
  logic [AW-1:0] exp_addr[RING];
  logic [DW-1:0] exp_wd  [RING];

  int cyc = 0;
  int free_at = 0;
  int to_cyc = -1;
  bit last_g = 1'b1;
  bit err_exp = 1'b0;

  always @(negedge clk) begin
    int i, done, acc;
    bit req0, req1, g, wr;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd, data;
    if (!rst_n) begin
      chk("reset h0", {h0_bus.waitrequest, h0_bus.readdatavalid, h0_bus.readdata}, {1'b1, 1'b0, 32'h0});
      chk("reset h1", {h1_bus.waitrequest, h1_bus.readdatavalid, h1_bus.readdata}, {1'b1, 1'b0, 32'h0});
      chk("reset agent", {a_bus.read, a_bus.write, a_bus.address, a_bus.writedata}, 64'h0);
      chk("reset err_o", err, 1'b0);
      for (int k = 0; k < RING; k++) begin
        for (int h = 0; h < 2; h++) begin
          exp_wrq[h][k] = 1'b1; exp_rdv[h][k] = 1'b0; exp_rd[h][k] = '0;
        end
        exp_rdc[k] = 1'b0; exp_wrc[k] = 1'b0; exp_addr[k] = '0; exp_wd[k] = '0;
      end
      free_at = cyc + 1;
      last_g  = 1'b1;
      err_exp = 1'b0;
      to_cyc  = -1;
    end else begin
      i = cyc % RING;
      chk($sformatf("h0 outputs cyc%0d", cyc), {h0_bus.waitrequest, h0_bus.readdatavalid, h0_bus.readdata},
          {exp_wrq[0][i], exp_rdv[0][i], exp_rd[0][i]});
      chk($sformatf("h1 outputs cyc%0d", cyc), {h1_bus.waitrequest, h1_bus.readdatavalid, h1_bus.readdata},
          {exp_wrq[1][i], exp_rdv[1][i], exp_rd[1][i]});
      chk($sformatf("agent cmd cyc%0d", cyc), {a_bus.read, a_bus.write}, {exp_rdc[i], exp_wrc[i]});
      if (exp_rdc[i] || exp_wrc[i])
        chk($sformatf("agent addr cyc%0d", cyc), a_bus.address, exp_addr[i]);
      if (exp_wrc[i])
        chk($sformatf("agent wdata cyc%0d", cyc), a_bus.writedata, exp_wd[i]);
      chk($sformatf("err_o cyc%0d", cyc), err, err_exp);
      exp_wrq[0][i] = 1'b1; exp_rdv[0][i] = 1'b0; exp_rd[0][i] = '0;
      exp_wrq[1][i] = 1'b1; exp_rdv[1][i] = 1'b0; exp_rd[1][i] = '0;
      exp_rdc[i] = 1'b0; exp_wrc[i] = 1'b0;

      // A new transaction is accepted when the arbiter is free and someone asks.
      req0 = h0_bus.read | h0_bus.write;
      req1 = h1_bus.read | h1_bus.write;
      if (cyc >= free_at && (req0 || req1)) begin
        g      = (req0 && req1) ? !last_g : req1;
        last_g = g;
        wr     = g ? h1_bus.write : h0_bus.write;
        ad     = g ? h1_bus.address : h0_bus.address;
        wd     = g ? h1_bus.writedata : h0_bus.writedata;
        if (int'(ad) >= MAP) begin
          done = cyc + 1;
          data = '0;
        end else begin
          acc = cyc + 1 + cfg_stall;
          for (int k = cyc + 1; k <= acc; k++) begin
            exp_rdc[k % RING] = !wr; exp_wrc[k % RING] = wr;
            exp_addr[k % RING] = ad; exp_wd[k % RING] = wd;
          end
          if (wr) begin
            done = acc + 1;
            data = '0;
          end else if (cfg_delay < 0) begin
            to_cyc = cyc + TMO;
            done   = to_cyc + 1;
            data   = '1;
          end else begin
            done = acc + cfg_delay + 1;
            data = cfg_rdata;
          end
        end
        exp_wrq[g][done % RING] = 1'b0;
        if (!wr) begin
          exp_rdv[g][(done + 1) % RING] = 1'b1;
          exp_rd[g][(done + 1) % RING]  = data;
        end
        free_at = wr ? done + 1 : done + 2;
      end
      if (cyc == to_cyc) err_exp = 1'b1;
      else if (err_clr)  err_exp = 1'b0;
    end
    cyc++;
  end

  // ---------------- host driver -------------------------------------------
  bit order[$];

  task automatic set_host(input int n, input bit wr, input bit rd, input logic [AW-1:0] ad,
                          input logic [DW-1:0] wd);
    if (n == 0) begin
      h0_bus.write = wr; h0_bus.read = rd; h0_bus.address = ad; h0_bus.writedata = wd;
    end else begin
      h1_bus.write = wr; h1_bus.read = rd; h1_bus.address = ad; h1_bus.writedata = wd;
    end
  endtask

  // Issues one command, holds it until waitrequest drops, collects read data.
  // lat = cycles from the request cycle to the waitrequest-low cycle.
  task automatic host_xfer(input int n, input bit wr, input bit rd, input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd, output logic [DW-1:0] rdat, output int lat);
    time t0;
    bit  ok;
    @(posedge clk); #1;
    set_host(n, wr, rd, ad, wd);
    t0 = $time; ok = 1'b0; lat = -1; rdat = '0;
    for (int t = 0; t < 600 && !ok; t++) begin
      @(negedge clk);
      if ((n == 0 ? h0_bus.waitrequest : h1_bus.waitrequest) == 1'b0) begin
        ok  = 1'b1;
        lat = int'(($time - t0 - 64'd4) / 64'd10);
      end
    end
    chk($sformatf("h%0d handshake within bound", n), ok, 1'b1);
    @(posedge clk); #1;
    set_host(n, 1'b0, 1'b0, '0, '0);
    if (ok && rd && !wr) begin
      @(negedge clk);
      chk($sformatf("h%0d readdatavalid after waitrequest", n),
          (n == 0 ? h0_bus.readdatavalid : h1_bus.readdatavalid), 1'b1);
      rdat   = (n == 0) ? h0_bus.readdata : h1_bus.readdata;
      t_hrdv = $time;
    end
    order.push_back(n[0]);
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    logic [DW-1:0] r0, r1;
    int l0, l1, na, nw;
    set_host(0, 0, 0, '0, '0);
    set_host(1, 0, 0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Simultaneous reads after reset, twice: grants alternate 0,1,0,1.
    cfg_stall = 1; cfg_delay = 2; cfg_rdata = 32'h1111_0000;
    order.delete();
    fork
      host_xfer(0, 0, 1, 16'h0008, '0, r0, l0);
      host_xfer(1, 0, 1, 16'h000C, '0, r1, l1);
    join
    chk("tie1 h0 data", r0, 32'h1111_0000);
    chk("tie1 h1 data", r1, 32'h1111_0000);
    fork
      host_xfer(0, 0, 1, 16'h0008, '0, r0, l0);
      host_xfer(1, 0, 1, 16'h000C, '0, r1, l1);
    join
    chk("tie order size", order.size(), 4);
    if (order.size() == 4)
      chk("tie order", {order[0], order[1], order[2], order[3]}, 4'b0101);

    // Host 0 alone, then a tie: host 1 now wins.
    cfg_stall = 0;
    order.delete();
    host_xfer(0, 1, 0, 16'h0001, 32'hA5A5_0001, r0, l0);
    fork
      host_xfer(0, 0, 1, 16'h0002, '0, r0, l0);
      host_xfer(1, 0, 1, 16'h0003, '0, r1, l1);
    join
    chk("pointer order size", order.size(), 3);
    if (order.size() == 3)
      chk("pointer order", {order[1], order[2]}, 2'b10);

    // Reserved read 0x0800: no agent traffic, zero data, 1-cycle latency.
    na = a_rd_cycles + a_wr_cycles;
    host_xfer(0, 0, 1, 16'h0800, '0, r0, l0);
    chk("reserved read data", r0, 32'h0);
    chk("reserved read latency", l0, 1);
    chk("reserved read agent idle", a_rd_cycles + a_wr_cycles, na);

    // First reserved word (MAP_WORDS) write is discarded.
    host_xfer(1, 1, 0, 16'h0400, 32'h5555_AAAA, r1, l1);
    chk("reserved write latency", l1, 1);
    chk("reserved write agent idle", a_rd_cycles + a_wr_cycles, na);

    // Last window word (MAP_WORDS-1) reaches the agent.
    cfg_delay = 1; cfg_rdata = 32'h3FF0_0001;
    na = a_rd_cycles;
    host_xfer(0, 0, 1, 16'h03FF, '0, r0, l0);
    chk("window top data", r0, 32'h3FF0_0001);
    chk("window top agent read cycles", a_rd_cycles - na, 1);

    // Host 1 write with agent stalling 3 cycles.
    cfg_stall = 3;
    nw = a_wr_cycles;
    host_xfer(1, 1, 0, 16'h0004, 32'h1234_5678, r1, l1);
    chk("stalled write a_write cycles", a_wr_cycles - nw, 4);
    chk("stalled write address", last_a_addr, 16'h0004);
    chk("stalled write data", last_a_wd, 32'h1234_5678);
    chk("stalled write latency", l1, 5);

    // Read and write together behave as a write.
    cfg_stall = 0;
    nw = a_wr_cycles; na = a_rd_cycles;
    host_xfer(0, 1, 1, 16'h0005, 32'h0BEE_F00D, r0, l0);
    chk("rd+wr write cycles", a_wr_cycles - nw, 1);
    chk("rd+wr read cycles", a_rd_cycles - na, 0);

    // Agent read returned 5 cycles after acceptance.
    cfg_delay = 5; cfg_rdata = 32'hCAFE_F00D;
    host_xfer(0, 0, 1, 16'h0010, '0, r0, l0);
    chk("slow read data", r0, 32'hCAFE_F00D);
    chk("slow read latency", l0, 7);
    chk("slow read rdv spacing", int'((t_hrdv - t_arv - 64'd4) / 64'd10), 2);

`ifdef TSN_CSR_TIMEOUT_EN
    cfg_delay = -1;
    host_xfer(0, 0, 1, 16'h0020, '0, r0, l0);
    chk("timeout read data", r0, 32'hFFFF_FFFF);
    chk("timeout latency", l0, TMO + 1);
    chk("timeout err_o set", err, 1'b1);
`endif
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_o after clear", err, 1'b0);

    // Reset while the arbiter waits in RDWAIT.
    cfg_stall = 0; cfg_delay = 20; cfg_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    set_host(0, 0, 1, 16'h0020, '0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    set_host(0, 0, 0, '0, '0);
    #1;
    chk("mid reset h0", {h0_bus.waitrequest, h0_bus.readdatavalid, h0_bus.readdata}, {1'b1, 1'b0, 32'h0});
    chk("mid reset h1", {h1_bus.waitrequest, h1_bus.readdatavalid, h1_bus.readdata}, {1'b1, 1'b0, 32'h0});
    chk("mid reset agent", {a_bus.read, a_bus.write, a_bus.address, a_bus.writedata}, 64'h0);
    chk("mid reset err_o", err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cfg_delay = 3; cfg_rdata = 32'h0BAD_F00D;
    host_xfer(0, 0, 1, 16'h0020, '0, r0, l0);
    chk("post reset read data", r0, 32'h0BAD_F00D);
    chk("post reset read latency", l0, 5);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1);
  end

endmodule
